// File: rtl/rgb_sample_accumulator.sv
// rgb_sample_accumulator
//
// Averages 2^SAMPLES_LOG2 signed fixed-point RGB samples into one pixel.
// Each average is rounded half up and saturated to RGB_WIDTH bits.
// The finished pixel is held on a registered valid/ready output together
// with a running pixel index. While a pixel is converting or waiting at
// the output, the block stalls the upstream multiply stage.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. The producer holds its payload stable while valid=1 and
// ready=0. in_ready is a decode of state only. out_valid, once set, stays
// high until the transfer.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   sample handshake (in_ready = 1 only in ACCUM)
//   in_r, in_g, in_b      signed channel samples, Q_BITS fraction bits
//   flush                 in ACCUM, drops the partial pixel (wins over in_valid)
//   out_valid / out_ready pixel handshake
//   out_r, out_g, out_b   averaged channels
//   pixel_idx             index of the pixel on out_*, wraps modulo 2^PIX_W
//   dbg_state             current FSM state (0 ACCUM, 1 CONVERT, 2 OUTPUT)
module rgb_sample_accumulator #(
    parameter int WIDTH        = 24,
    parameter int Q_BITS       = 12,
    parameter int RGB_WIDTH    = 8,
    parameter int SAMPLES_LOG2 = 2,
    parameter int PIX_W        = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [WIDTH-1:0]     in_r,
    input  logic signed [WIDTH-1:0]     in_g,
    input  logic signed [WIDTH-1:0]     in_b,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [RGB_WIDTH-1:0]        out_r,
    output logic [RGB_WIDTH-1:0]        out_g,
    output logic [RGB_WIDTH-1:0]        out_b,
    output logic [PIX_W-1:0]            pixel_idx,
    output logic [1:0]                  dbg_state
);

    // Accumulators carry SAMPLES_LOG2 guard bits so N samples cannot overflow.
    localparam int AW = WIDTH + SAMPLES_LOG2;
    // One more bit so adding the rounding constant cannot overflow.
    localparam int RW = AW + 1;

    localparam logic signed [RW-1:0] HALF =
        {{(RW-Q_BITS){1'b0}}, 1'b1, {(Q_BITS-1){1'b0}}};
    localparam logic signed [RW-1:0] LIMIT =
        {{(RW-Q_BITS-RGB_WIDTH-1){1'b0}}, 1'b1, {(Q_BITS+RGB_WIDTH){1'b0}}};

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        CONVERT = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic signed [AW-1:0]    acc_r;
    logic signed [AW-1:0]    acc_g;
    logic signed [AW-1:0]    acc_b;
    logic [SAMPLES_LOG2-1:0] cnt;
    logic                    accept;
    logic                    last;
    logic                    handshake;

    // avg = acc >>> SAMPLES_LOG2, round half up, clamp to [0, 2^RGB_WIDTH-1].
    function automatic logic [RGB_WIDTH-1:0] convert(input logic signed [AW-1:0] acc);
        logic signed [RW-1:0] avg;
        logic signed [RW-1:0] rnd;
        avg = $signed({acc[AW-1], acc}) >>> SAMPLES_LOG2;
        rnd = avg + HALF;
        if (rnd[RW-1]) begin
            convert = '0;
        end else if (rnd >= LIMIT) begin
            convert = '1;
        end else begin
            convert = rnd[Q_BITS+RGB_WIDTH-1:Q_BITS];
        end
    endfunction

    assign in_ready  = (state == ACCUM);
    assign dbg_state = state;
    assign accept    = (state == ACCUM) && in_valid && !flush;
    assign last      = (cnt == {SAMPLES_LOG2{1'b1}});
    assign handshake = (state == OUTPUT) && out_valid && out_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (accept && last) state_nxt = CONVERT;
            CONVERT: state_nxt = OUTPUT;
            OUTPUT:  if (handshake) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            acc_r     <= '0;
            acc_g     <= '0;
            acc_b     <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_r     <= '0;
            out_g     <= '0;
            out_b     <= '0;
            pixel_idx <= '0;
        end else begin
            state <= state_nxt;

            if (handshake) begin
                acc_r <= '0;
                acc_g <= '0;
                acc_b <= '0;
            end else if (state == ACCUM && flush) begin
                acc_r <= '0;
                acc_g <= '0;
                acc_b <= '0;
                cnt   <= '0;
            end else if (accept) begin
                acc_r <= acc_r + AW'(in_r);
                acc_g <= acc_g + AW'(in_g);
                acc_b <= acc_b + AW'(in_b);
                // The last sample wraps the counter back to 0 naturally.
                cnt   <= cnt + 1'b1;
            end

            if (state == CONVERT) begin
                out_r     <= convert(acc_r);
                out_g     <= convert(acc_g);
                out_b     <= convert(acc_b);
                out_valid <= 1'b1;
            end else if (handshake) begin
                out_valid <= 1'b0;
                pixel_idx <= pixel_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rgb_sample_accumulator.sv
module tb_rgb_sample_accumulator;
  localparam int WIDTH = 24;
  localparam int Q_BITS = 12;
  localparam int RGB_WIDTH = 8;
  localparam int SL = 2;
  localparam int PIX_W = 2;
  localparam int N = 4;
  localparam int EW = PIX_W + 3 * RGB_WIDTH;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_r = '0;
  logic [WIDTH-1:0]     in_g = '0;
  logic [WIDTH-1:0]     in_b = '0;
  logic                 flush = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [RGB_WIDTH-1:0] out_r;
  logic [RGB_WIDTH-1:0] out_g;
  logic [RGB_WIDTH-1:0] out_b;
  logic [PIX_W-1:0]     pixel_idx;
  logic [1:0]           dbg_state;

  int tests_run = 0;
  int tests_failed = 0;
  logic [EW-1:0] exp_q[$];
  logic [PIX_W-1:0] exp_idx = '0;
  longint sum_r, sum_g, sum_b;

  rgb_sample_accumulator #(
    .WIDTH(WIDTH), .Q_BITS(Q_BITS), .RGB_WIDTH(RGB_WIDTH),
    .SAMPLES_LOG2(SL), .PIX_W(PIX_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .pixel_idx(pixel_idx), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model of one channel conversion
  function automatic longint sx(input logic [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] s;
    s = v;
    return longint'(s);
  endfunction

  function automatic logic [RGB_WIDTH-1:0] conv(input longint sum);
    longint avg, r;
    avg = sum >>> SL;
    r = avg + (longint'(1) << (Q_BITS - 1));
    if (r < 0) return '0;
    if (r >= (longint'(1) << (Q_BITS + RGB_WIDTH))) return '1;
    return RGB_WIDTH'(r >>> Q_BITS);
  endfunction

  // driver tasks (called and returning at a falling edge)
  task automatic send_sample(input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] g,
                             input logic [WIDTH-1:0] b);
    in_valid = 1'b1; in_r = r; in_g = g; in_b = b;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL send_ready: in_ready=%b required 1", in_ready);
    end
    sum_r += sx(r); sum_g += sx(g); sum_b += sx(b);
    @(negedge clk);
  endtask

  task automatic push_pixel(input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] g,
                            input logic [WIDTH-1:0] b);
    sum_r = 0; sum_g = 0; sum_b = 0;
    for (int i = 0; i < N; i++) send_sample(r, g, b);
    in_valid = 1'b0;
    exp_q.push_back({exp_idx, conv(sum_r), conv(sum_g), conv(sum_b)});
    exp_idx++;
  endtask

  task automatic push_random_pixel();
    sum_r = 0; sum_g = 0; sum_b = 0;
    for (int i = 0; i < N; i++)
      send_sample(WIDTH'($urandom_range(0, 32'hFF_FFFF)), WIDTH'($urandom_range(0, 32'h0F_FFFF)),
                  WIDTH'($urandom_range(32'hF0_0000, 32'hFF_FFFF)));
    in_valid = 1'b0;
    exp_q.push_back({exp_idx, conv(sum_r), conv(sum_g), conv(sum_b)});
    exp_idx++;
  endtask

  // scoreboard: wait for a pixel, compare with the queue head, then take it
  task automatic collect_pixel();
    int n;
    logic [EW-1:0] e;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL scoreboard_empty: got pixel %h with no expectation",
               {pixel_idx, out_r, out_g, out_b});
      return;
    end
    e = exp_q.pop_front();
    if (out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL out_valid_timeout: out_valid=%b required 1", out_valid);
      return;
    end
    if ({pixel_idx, out_r, out_g, out_b} !== e) begin
      tests_failed++;
      $display("FAIL pixel: idx/r/g/b=%0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d",
               pixel_idx, out_r, out_g, out_b, e[EW-1:3*RGB_WIDTH],
               e[3*RGB_WIDTH-1:2*RGB_WIDTH], e[2*RGB_WIDTH-1:RGB_WIDTH], e[RGB_WIDTH-1:0]);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL after_handshake: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b1; in_r = 24'h7FFFFF; in_g = 24'h7FFFFF; in_b = 24'h7FFFFF;
    flush = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    exp_idx = '0;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({out_valid, in_ready, out_r, out_g, out_b, pixel_idx, dbg_state} !==
        {1'b0, 1'b1, {(3*RGB_WIDTH){1'b0}}, {PIX_W{1'b0}}, 2'd0}) begin
      tests_failed++;
      $display("FAIL reset_state: valid=%b ready=%b rgb=%h idx=%0d st=%0d required 0 1 0 0 0",
               out_valid, in_ready, {out_r, out_g, out_b}, pixel_idx, dbg_state);
    end
    do_reset();
  endtask

  task automatic test_basic();
    push_pixel(24'h080000, 24'h080000, 24'h080000);
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_convert: out_valid=%b in_ready=%b required 0 0", out_valid, in_ready);
    end
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_latency: out_valid=%b in_ready=%b required 1 0", out_valid, in_ready);
    end
    collect_pixel();
  endtask

  task automatic test_rounding();
    push_pixel(24'h064800, 24'h0647FF, 24'h064000);
    collect_pixel();
  endtask

  task automatic test_saturation();
    push_pixel(24'h7FFFFF, 24'hF00000, 24'h0FF7FF);
    collect_pixel();
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      push_random_pixel();
      collect_pixel();
    end
  endtask

  task automatic test_back_to_back();
    push_pixel(24'h010000, 24'h020000, 24'h030000);
    collect_pixel();
    push_pixel(24'h0A0800, 24'hFFF000, 24'h050000);
    collect_pixel();
  endtask

  task automatic test_backpressure();
    logic [EW-1:0] e;
    push_pixel(24'h032000, 24'h064000, 24'h096000);
    in_valid = 1'b1; in_r = 24'h7FFFFF; in_g = 24'h7FFFFF; in_b = 24'h7FFFFF;
    @(negedge clk);
    e = exp_q[0];
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          {out_r, out_g, out_b} !== e[3*RGB_WIDTH-1:0]) begin
        tests_failed++;
        $display("FAIL backpressure_hold: valid=%b ready=%b rgb=%h required 1 0 %h",
                 out_valid, in_ready, {out_r, out_g, out_b}, e[3*RGB_WIDTH-1:0]);
      end
      @(negedge clk);
    end
    collect_pixel();
    push_pixel(24'h014000, 24'h028000, 24'h03C000);
    collect_pixel();
  endtask

  task automatic test_flush();
    logic [EW-1:0] e;
    sum_r = 0;
    send_sample(24'h0C8000, 24'h0C8000, 24'h0C8000);
    send_sample(24'h0C8000, 24'h0C8000, 24'h0C8000);
    flush = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    push_pixel(24'h00A000, 24'h00A000, 24'h00A000);
    // flush during CONVERT and OUTPUT must be ignored
    flush = 1'b1;
    repeat (3) @(negedge clk);
    flush = 1'b0;
    e = exp_q[0];
    tests_run++;
    if (out_valid !== 1'b1 || {pixel_idx, out_r, out_g, out_b} !== e) begin
      tests_failed++;
      $display("FAIL flush_in_output: valid=%b pix=%h required 1 %h",
               out_valid, {pixel_idx, out_r, out_g, out_b}, e);
    end
    collect_pixel();
  endtask

  task automatic test_index_wrap();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push_random_pixel();
      collect_pixel();
    end
    // async reset while a pixel is pending (index 1 on the output)
    push_pixel(24'h050000, 24'h050000, 24'h050000);
    repeat (2) @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b1 || pixel_idx !== 2'd1) begin
      tests_failed++;
      $display("FAIL pending_before_reset: valid=%b idx=%0d required 1 1", out_valid, pixel_idx);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, out_r, out_g, out_b, pixel_idx} !== '0) begin
      tests_failed++;
      $display("FAIL async_reset: valid=%b rgb=%h idx=%0d required all 0",
               out_valid, {out_r, out_g, out_b}, pixel_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    exp_idx = '0;
    @(negedge clk);
    // reset mid-pixel discards the partial sums
    send_sample(24'h0C8000, 24'h0C8000, 24'h0C8000);
    send_sample(24'h0C8000, 24'h0C8000, 24'h0C8000);
    in_valid = 1'b0;
    do_reset();
    push_pixel(24'h00A000, 24'h00A000, 24'h00A000);
    collect_pixel();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_index_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
